// File: rtl/register_bank_pkg.sv
// Shared constants, state encoding and sizing helpers for the register bank loader/streamer pair.
// REGISTER_BANK_STREAMER_HEADER_EN adds the HEADER state used by the optional header beat.
package register_bank_pkg;

    localparam int BANK_REG_SIZE = 32;
    localparam logic [15:0] HEADER_MAGIC = 16'hA55A;

`ifdef REGISTER_BANK_STREAMER_HEADER_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        SEND   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
`endif

    function automatic bit stream_width_ok(input int stream_width);
        case (stream_width)
            32, 64, 128, 256: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // Beats needed to carry bank_size registers, rounding a partial last beat up.
    function automatic int beats_per_bank(input int bank_size, input int stream_width);
        int regs_per_beat;
        regs_per_beat = stream_width / BANK_REG_SIZE;
        return (bank_size + regs_per_beat - 1) / regs_per_beat;
    endfunction

endpackage

// File: rtl/register_bank_streamer_if.sv
// AXI-Stream bundle carrying the serialised register bank.
interface register_bank_streamer_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/register_bank_streamer.sv
// Snapshots a flat register bank on start and streams it out as AXI-Stream beats.
// Define REGISTER_BANK_STREAMER_HEADER_EN to prepend a {A55A, BANK_SIZE} header beat.
module register_bank_streamer
    import register_bank_pkg::*;
#(
    parameter int BANK_SIZE        = 8,
    parameter int CMD_STREAM_WIDTH = 32
) (
    input  logic                                aclk,
    input  logic                                resetn,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    input  logic [BANK_SIZE*BANK_REG_SIZE-1:0]  registers,
    register_bank_streamer_if.master            m_axis
);

    localparam int NUM_BEATS = beats_per_bank(BANK_SIZE, CMD_STREAM_WIDTH);
    localparam int IDX_W     = ($clog2(NUM_BEATS + 1) > 1) ? $clog2(NUM_BEATS + 1) : 1;
    localparam int BANK_W    = BANK_SIZE * BANK_REG_SIZE;
    localparam int PAD_W     = NUM_BEATS * CMD_STREAM_WIDTH;
    localparam int SEL_W     = $clog2(PAD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              w_idx_nxt;
    logic [BANK_W-1:0]             r_shadow;
    logic [BANK_W-1:0]             w_shadow_nxt;
    logic [PAD_W-1:0]              w_padded;
    logic [SEL_W-1:0]              w_sel;
    logic [CMD_STREAM_WIDTH-1:0]   w_tdata_nxt;
    logic [CMD_STREAM_WIDTH-1:0]   r_tdata;
    logic                          w_tlast_nxt;
    logic                          r_tlast;
    logic                          r_tvalid;
    logic                          r_busy;
    logic                          w_done_nxt;
    logic                          r_done;
    logic                          w_hs;

    assign w_hs = r_tvalid && m_axis.tready;

    // Next-state, beat index and snapshot capture.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_shadow_nxt = r_shadow;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shadow_nxt = registers;
                    w_idx_nxt    = '0;
`ifdef REGISTER_BANK_STREAMER_HEADER_EN
                    w_state_nxt  = HEADER;
`else
                    w_state_nxt  = SEND;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef REGISTER_BANK_STREAMER_HEADER_EN
            HEADER: begin
                if (w_hs) begin
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = HEADER;
                end
            end
`endif
            SEND: begin
                if (w_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_state_nxt = SEND;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Beat payload for the next cycle; slots past BANK_SIZE read as zero padding.
    always_comb begin
        w_padded              = '0;
        w_padded[BANK_W-1:0]  = w_shadow_nxt;
        w_sel                 = SEL_W'(w_idx_nxt) * SEL_W'(CMD_STREAM_WIDTH);
        w_tdata_nxt           = '0;
        w_tlast_nxt           = 1'b0;
        if (w_state_nxt == SEND) begin
            w_tdata_nxt = w_padded[w_sel +: CMD_STREAM_WIDTH];
            w_tlast_nxt = (w_idx_nxt == LAST_IDX);
        end
`ifdef REGISTER_BANK_STREAMER_HEADER_EN
        else if (w_state_nxt == HEADER) begin
            w_tdata_nxt[15:0]  = 16'(BANK_SIZE);
            w_tdata_nxt[31:16] = HEADER_MAGIC;
            w_tlast_nxt        = 1'b0;
        end
`endif
        else begin
            w_tdata_nxt = '0;
            w_tlast_nxt = 1'b0;
        end
    end

    // State, index and shadow bank registers.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    // Registered stream and status outputs.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_tvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            r_tvalid <= (w_state_nxt != IDLE);
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
            r_tlast  <= w_tlast_nxt;
            r_tdata  <= w_tdata_nxt;
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tdata  = r_tdata;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_register_bank_streamer.sv
// Scoreboard bench: three streamer instances (8x32, 8x128, 6x128) checked against a bank-packing model.
module tb_register_bank_streamer;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } beat_t;

    logic         aclk = 1'b0;
    logic         resetn;
    logic         rdy;
    logic         start32, start128, start6;
    logic [255:0] regs32, regs128;
    logic [191:0] regs6;
    logic         busy32, busy128, busy6, done32, done128, done6;
    logic [1:0]   sel;
    logic         obs_valid, obs_last, obs_busy, obs_done;
    logic [255:0] obs_data;
    beat_t        exp_q[$];
    int           tests = 0;
    int           fails = 0;

    always #5 aclk = ~aclk;

    register_bank_streamer_if #(.DATA_W(32))  ax32();
    register_bank_streamer_if #(.DATA_W(128)) ax128();
    register_bank_streamer_if #(.DATA_W(128)) ax6();

    assign ax32.tready  = rdy;
    assign ax128.tready = rdy;
    assign ax6.tready   = rdy;

    register_bank_streamer #(.BANK_SIZE(8), .CMD_STREAM_WIDTH(32)) u_dut32 (
        .aclk(aclk), .resetn(resetn), .start(start32), .busy(busy32), .done(done32),
        .registers(regs32), .m_axis(ax32));
    register_bank_streamer #(.BANK_SIZE(8), .CMD_STREAM_WIDTH(128)) u_dut128 (
        .aclk(aclk), .resetn(resetn), .start(start128), .busy(busy128), .done(done128),
        .registers(regs128), .m_axis(ax128));
    register_bank_streamer #(.BANK_SIZE(6), .CMD_STREAM_WIDTH(128)) u_dut6 (
        .aclk(aclk), .resetn(resetn), .start(start6), .busy(busy6), .done(done6),
        .registers(regs6), .m_axis(ax6));

    always_comb begin
        obs_data = '0;
        case (sel)
            2'd0: begin
                obs_valid = ax32.tvalid; obs_last = ax32.tlast; obs_data[31:0] = ax32.tdata;
                obs_busy = busy32; obs_done = done32;
            end
            2'd1: begin
                obs_valid = ax128.tvalid; obs_last = ax128.tlast; obs_data[127:0] = ax128.tdata;
                obs_busy = busy128; obs_done = done128;
            end
            default: begin
                obs_valid = ax6.tvalid; obs_last = ax6.tlast; obs_data[127:0] = ax6.tdata;
                obs_busy = busy6; obs_done = done6;
            end
        endcase
    end

    function automatic logic [255:0] seq_bank(input int base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = 32'(base + i);
        return b;
    endfunction

    task automatic push_packet(input logic [255:0] bank, input int bank_size, input int width);
        int    r;
        int    nb;
        beat_t b;
        r  = width / 32;
        nb = (bank_size + r - 1) / r;
`ifdef REGISTER_BANK_STREAMER_HEADER_EN
        b.data = '0;
        b.data[15:0]  = bank_size[15:0];
        b.data[31:16] = 16'hA55A;
        b.last = 1'b0;
        exp_q.push_back(b);
`endif
        for (int beat = 0; beat < nb; beat++) begin
            b.data = '0;
            for (int k = 0; k < r; k++) begin
                if (beat * r + k < bank_size) b.data[32*k +: 32] = bank[32*(beat*r+k) +: 32];
            end
            b.last = (beat == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_start(input logic v);
        case (sel)
            2'd0:    start32  = v;
            2'd1:    start128 = v;
            default: start6   = v;
        endcase
    endtask

    task automatic send_start(input logic [255:0] bank, input int bank_size, input int width);
        case (sel)
            2'd0:    regs32  = bank;
            2'd1:    regs128 = bank;
            default: regs6   = bank[191:0];
        endcase
        push_packet(bank, bank_size, width);
        set_start(1'b1);
        @(posedge aclk); #1;
        set_start(1'b0);
    endtask

    // mode 0: tready=1; mode 1: tready 1,0,0 pattern with register churn and stray start; mode 2: start held high
    task automatic drain(input int mode);
        int           cyc = 0;
        bit           got_last = 1'b0;
        bit           stalled = 1'b0;
        logic [255:0] pd = '0;
        logic         pl = 1'b0;
        beat_t        e;
        while (!got_last && cyc < 100) begin
            rdy = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            if (mode == 1 && cyc == 2) regs32 = ~regs32;
            if (mode == 1) start32 = (cyc == 4);
            if (mode == 2) start32 = 1'b1;
            @(negedge aclk);
            tests++;
            if (obs_valid !== 1'b1 || obs_busy !== 1'b1) begin
                fails++; $display("FAIL valid_busy cyc=%0d got valid=%b busy=%b need 1/1", cyc, obs_valid, obs_busy);
            end
            if (stalled) begin
                tests++;
                if (obs_data !== pd || obs_last !== pl) begin
                    fails++; $display("FAIL stall_hold got %h/%b need %h/%b", obs_data, obs_last, pd, pl);
                end
            end
            if (obs_valid && rdy) begin
                stalled = 1'b0;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL extra_beat got %h with empty scoreboard need none", obs_data);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_data !== e.data || obs_last !== e.last) begin
                        fails++; $display("FAIL beat got %h last=%b need %h last=%b", obs_data, obs_last, e.data, e.last);
                    end
                end
                if (obs_last === 1'b1) got_last = 1'b1;
            end else begin
                stalled = obs_valid;
                pd = obs_data;
                pl = obs_last;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        start32 = 1'b0;
        tests++;
        if (!got_last) begin
            fails++; $display("FAIL timeout no tlast after %0d cycles need tlast", cyc);
        end
        @(negedge aclk);
        tests++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_valid !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL done_pulse got done=%b busy=%b valid=%b left=%0d need 1/0/0/0",
                     obs_done, obs_busy, obs_valid, exp_q.size());
        end
    endtask

    task automatic test_reset;
        @(posedge aclk); @(posedge aclk); @(negedge aclk);
        tests++;
        if ({ax32.tvalid, ax32.tlast, busy32, done32, ax128.tvalid, busy128, ax6.tvalid, busy6} !== 8'h00
            || ax32.tdata !== 32'h0 || ax128.tdata !== 128'h0 || ax6.tdata !== 128'h0) begin
            fails++; $display("FAIL reset_state got non-zero outputs need all zero");
        end
        resetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_stream32;
        sel = 2'd0;
        @(negedge aclk);
        tests++;
        if (busy32 !== 1'b0 || ax32.tvalid !== 1'b0) begin
            fails++; $display("FAIL idle got busy=%b valid=%b need 0/0", busy32, ax32.tvalid);
        end
        @(posedge aclk); #1;
        send_start(seq_bank(32'h1000), 8, 32);
        drain(0);
        @(negedge aclk);
        tests++;
        if (done32 !== 1'b0) begin
            fails++; $display("FAIL done_width got done=%b need 0", done32);
        end
    endtask

    task automatic test_wide;
        sel = 2'd1;
        @(posedge aclk); #1;
        send_start(seq_bank(32'h1000), 8, 128);
        drain(0);
        sel = 2'd2;
        @(posedge aclk); #1;
        send_start(seq_bank(32'h1000), 6, 128);
        drain(0);
    endtask

    task automatic test_backpressure;
        sel = 2'd0;
        @(posedge aclk); #1;
        send_start(seq_bank(32'h2000), 8, 32);
        drain(1);
        repeat (3) begin
            @(negedge aclk);
            tests++;
            if (ax32.tvalid !== 1'b0 || busy32 !== 1'b0) begin
                fails++; $display("FAIL one_packet got valid=%b busy=%b need 0/0", ax32.tvalid, busy32);
            end
        end
    endtask

    task automatic test_back_to_back;
        sel = 2'd0;
        @(posedge aclk); #1;
        send_start(seq_bank(32'h3000), 8, 32);
        drain(2);
        @(negedge aclk);
        tests++;
        if (busy32 !== 1'b0 || ax32.tvalid !== 1'b0) begin
            fails++; $display("FAIL start_on_last got busy=%b valid=%b need 0/0", busy32, ax32.tvalid);
        end
        @(posedge aclk); #1;
        send_start(seq_bank(32'h4000), 8, 32);
        drain(0);
        send_start(seq_bank(32'h5000), 8, 32);
        drain(0);
    endtask

    task automatic test_reset_mid;
        sel = 2'd0;
        rdy = 1'b1;
        @(posedge aclk); #1;
        send_start(seq_bank(32'h6000), 8, 32);
        repeat (4) @(posedge aclk);
        #1 resetn = 1'b0;
        #1;
        tests++;
        if (ax32.tvalid !== 1'b0 || busy32 !== 1'b0 || ax32.tlast !== 1'b0 || ax32.tdata !== 32'h0) begin
            fails++; $display("FAIL reset_mid got valid=%b busy=%b data=%h need 0/0/0", ax32.tvalid, busy32, ax32.tdata);
        end
        @(negedge aclk);
        resetn = 1'b1;
        exp_q.delete();
        @(posedge aclk); #1;
        send_start(seq_bank(32'h7000), 8, 32);
        drain(0);
    endtask

    initial begin
        resetn = 1'b0; rdy = 1'b1; sel = 2'd0;
        start32 = 1'b0; start128 = 1'b0; start6 = 1'b0;
        regs32 = '0; regs128 = '0; regs6 = '0;
        test_reset();
        test_stream32();
        test_wide();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish need finish before 200us");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_bank_streamer.md
Name: register_bank_streamer

Overview:
- Transmit-side counterpart of the register bank loader.
- On a start pulse, snapshots a flat bank of 32-bit registers and serialises it as an AXI-Stream.
- Each beat packs CMD_STREAM_WIDTH/32 registers, lowest register in the lowest bits; tlast marks the final beat.
- Used to read back or forward register state into the command stream path, e.g. state readback or bank-to-bank copy.

Parameters:
- BANK_SIZE, 8, number of 32-bit registers in the bank (>=1).
- CMD_STREAM_WIDTH, 32, stream data width; allowed values 32, 64, 128, 256.
- BANK_REG_SIZE (localparam), 32, width of one register.

Ports:
- aclk  input  1  clock; all logic rising-edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to snapshot and send the bank.
- busy  output  1  high from accepted start until the last beat handshakes.
- done  output  1  one-cycle pulse the cycle after the last beat handshake.
- registers  input  BANK_SIZE*32  flat register bank; register i is at bits [32*i +: 32].
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tlast  output  1  final beat of the bank.
- m_axis_tdata  output  CMD_STREAM_WIDTH  beat payload.

Behaviour:
- Reset (asynchronous, resetn=0):
  - busy=0, done=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - Beat index=0, state=IDLE. Takes effect immediately, including mid-transfer; the partial packet is abandoned.
- Derived constants:
  - R = CMD_STREAM_WIDTH/32 (registers per beat).
  - NUM_BEATS = ceil(BANK_SIZE/R).
  - Beat index width = max(1, $clog2(NUM_BEATS+1)).
- States:
  - IDLE: busy=0, tvalid=0. If start=1, copy registers into a shadow buffer, set index=0, go to SEND. busy and tvalid rise the next cycle, so first-beat latency is 1 cycle.
  - SEND:
    - tvalid=1; tdata = shadow registers [index*R .. index*R+R-1]. Register slots at or beyond BANK_SIZE are zero-padded.
    - tlast=1 only when index==NUM_BEATS-1.
    - On tvalid&&tready: if not last, index+1; if last, go to IDLE with done=1 for one cycle.
- AXI rules:
  - tvalid is never deasserted without a handshake.
  - tdata and tlast are stable while tvalid&&!tready.
  - tvalid does not depend combinationally on tready.
  - With tready held high, one beat per cycle and no bubbles.
- Snapshot: changes on registers after start is accepted do not affect the packet in flight.
- start while busy=1: ignored, no queueing. This includes start in the same cycle as the last handshake; the next start is accepted only in IDLE, the cycle after done.
- Back-to-back: start asserted in the cycle done=1 is accepted, so the minimum gap between packets is one idle cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: REGISTER_BANK_STREAMER_HEADER_EN.
- Defined:
  - One header beat precedes the payload.
  - Header tdata[15:0]=BANK_SIZE, tdata[31:16]=16'hA55A, all higher bits 0.
  - Header beat has tlast=0 and the same handshake rules; total beats = NUM_BEATS+1.
  - The shadow snapshot is still taken at start acceptance.
- Undefined: no header; first beat is register payload. Header logic and the extra index state are absent.

Decomposition:
- Shared package register_bank_pkg:
  - BANK_REG_SIZE=32.
  - Header magic 16'hA55A.
  - Allowed stream widths.
  - State typedef {IDLE, SEND} (plus HEADER under the macro).
  - Beats-per-bank function ceil(BANK_SIZE/R), shared with the loader.
- No sub-module: the beat mux is a single indexed part-select of the zero-padded shadow vector, kept in-module.

Test Plan:
- BANK_SIZE=8, width 32, reg i=32'h1000+i, tready=1, start pulse → busy rises next cycle; 8 beats of 1000..1007 on consecutive cycles; tlast only on beat 7; done pulse the cycle after; busy=0.
- BANK_SIZE=8, width 128 → 2 beats: beat0 tdata={1003,1002,1001,1000}, beat1={1007,...,1004}, tlast on beat1.
- BANK_SIZE=6, width 128 → 2 beats; beat1={0,0,1005,1004}, tlast=1.
- Backpressure: tready toggles 1,0,0,1,... and registers change after start → tdata/tlast held during stalls; payload equals the snapshot taken at start; start pulses while busy are ignored (exactly one packet sent).
- Reset mid-packet: resetn low after beat 3 → tvalid=0 and busy=0 immediately; a new start after release sends from beat 0 with a full tlast-terminated packet.
- With REGISTER_BANK_STREAMER_HEADER_EN, BANK_SIZE=8, width 32 → first beat 32'hA55A0008 with tlast=0, then 8 payload beats; 9 beats total.
